// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    localparam int MAX_WIDTH = 64;

    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

    // Callers pass a zero-extended operand and truncate the result back to WIDTH.
    function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                   input logic negate);
        return negate ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Sequencer for seq_multiplier: state, iteration counter, Busy/Ready and the early-exit decision.
// Build option MUL_EARLY_EXIT_EN adds the remaining-bits-zero exit from CALC.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cntWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             run_i,
`ifdef MUL_EARLY_EXIT_EN
    input  logic             remZero_i,
    output logic             earlyExit_o,
`endif
    output mul_state_t       state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             accept_o,
    output logic             busy_o,
    output logic             ready_o
);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exitNow;

`ifdef MUL_EARLY_EXIT_EN
    assign exitNow     = (state_q == CALC) && remZero_i;
    assign earlyExit_o = exitNow;
`else
    assign exitNow = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (run_i) begin
                    accept_o = 1'b1;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (exitNow) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;
    assign busy_o  = (state_q == CALC) || (state_q == FIX);
    assign ready_o = (state_q == DONE);

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Build option MUL_EARLY_EXIT_EN finishes as soon as the unprocessed multiplier bits are all zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               Run,
    input  logic               Signed_in,
    input  logic [WIDTH-1:0]   Multiplier_in,
    input  logic [WIDTH-1:0]   Multiplicand_in,
    output logic [2*WIDTH-1:0] Product_out,
    output logic               Busy,
    output logic               Ready
);

    localparam int CNT_W = cntWidth(WIDTH);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               earlyExit;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   mplierAbs;
    logic [WIDTH-1:0]   mcandAbs;
    logic [WIDTH:0]     sum;

`ifdef MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   lowMask;
    logic               remZero;

    // The low cnt bits of product_q are the multiplier bits not yet consumed.
    assign lowMask = WIDTH'(((WIDTH+1)'(1) << cnt) - (WIDTH+1)'(1));
    assign remZero = ((product_q[WIDTH-1:0] & lowMask) == '0);
`endif

    mul_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .run_i       (Run),
`ifdef MUL_EARLY_EXIT_EN
        .remZero_i   (remZero),
        .earlyExit_o (earlyExit),
`endif
        .state_o     (state),
        .cnt_o       (cnt),
        .accept_o    (accept),
        .busy_o      (Busy),
        .ready_o     (Ready)
    );

`ifndef MUL_EARLY_EXIT_EN
    assign earlyExit = 1'b0;
`endif

    assign mplierAbs = WIDTH'(abs_w(MAX_WIDTH'(Multiplier_in),
                                    Signed_in & Multiplier_in[WIDTH-1]));
    assign mcandAbs  = WIDTH'(abs_w(MAX_WIDTH'(Multiplicand_in),
                                    Signed_in & Multiplicand_in[WIDTH-1]));

    assign sum = product_q[0] ? ({1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                              :  {1'b0, product_q[2*WIDTH-1:WIDTH]};

    // Magnitudes are multiplied unsigned; the sign is reapplied once in FIX.
    always_comb begin
        product_d = product_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        if (accept) begin
            mcand_d   = mcandAbs;
            product_d = {{WIDTH{1'b0}}, mplierAbs};
            neg_d     = Signed_in & (Multiplier_in[WIDTH-1] ^ Multiplicand_in[WIDTH-1]);
        end else begin
            case (state)
                CALC: begin
                    if (earlyExit) begin
                        product_d = product_q >> cnt;
                    end else begin
                        product_d = {sum, product_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (neg_q) begin
                        product_d = ~product_q + (2*WIDTH)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            product_q <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
        end else begin
            product_q <= product_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
        end
    end

    assign Product_out = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier at WIDTH=32 and WIDTH=8.
// Latency expectations follow MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        Reset_n;

    logic        run32, sgn32, busy32, ready32;
    logic [31:0] mplier32, mcand32;
    logic [63:0] prod32;

    logic        run8, sgn8, busy8, ready8;
    logic [7:0]  mplier8, mcand8;
    logic [15:0] prod8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32)) dut32 (
        .clk             (clk),
        .Reset_n         (Reset_n),
        .Run             (run32),
        .Signed_in       (sgn32),
        .Multiplier_in   (mplier32),
        .Multiplicand_in (mcand32),
        .Product_out     (prod32),
        .Busy            (busy32),
        .Ready           (ready32)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk             (clk),
        .Reset_n         (Reset_n),
        .Run             (run8),
        .Signed_in       (sgn8),
        .Multiplier_in   (mplier8),
        .Multiplicand_in (mcand8),
        .Product_out     (prod8),
        .Busy            (busy8),
        .Ready           (ready8)
    );

    typedef struct {
        string       name;
        bit          use8;
        bit          sgn;
        logic [31:0] mplier;
        logic [31:0] mcand;
        logic [63:0] expected;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Independent reference: native multiplication of the sign- or zero-extended operands.
    function automatic logic [63:0] refProduct(input bit use8, input bit sgn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (use8) begin
            x = sgn ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            y = sgn ? longint'($signed(b[7:0])) : longint'(b[7:0]);
            return {48'd0, 16'(x * y)};
        end
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        return 64'(x * y);
    endfunction

    // Edges from the accept edge (counted as 1) to the edge after which Ready is high.
    function automatic int expLatency(input bit use8, input bit sgn, input logic [31:0] mplier);
        int          width;
        int          h;
        int          calc;
        logic [31:0] mag;
        width = use8 ? 8 : 32;
        mag   = use8 ? {24'd0, mplier[7:0]} : mplier;
        if (sgn && mag[width-1]) mag = ~mag + 32'd1;
        if (use8) mag = mag & 32'h0000_00FF;
        h = -1;
        for (int i = 0; i < width; i++) if (mag[i]) h = i;
        calc = (h < 0) ? 1 : ((h + 2 < width) ? h + 2 : width);
`ifdef MUL_EARLY_EXIT_EN
        return 2 + calc;
`else
        return (calc > 0) ? width + 2 : 0;
`endif
    endfunction

    task automatic applyStimulus(input bit use8, input bit sgn,
                                 input logic [31:0] mplier, input logic [31:0] mcand);
        @(negedge clk);
        if (use8) begin
            sgn8 = sgn; mplier8 = mplier[7:0]; mcand8 = mcand[7:0]; run8 = 1'b1;
        end else begin
            sgn32 = sgn; mplier32 = mplier; mcand32 = mcand; run32 = 1'b1;
        end
        @(posedge clk);
        #1;
        run8  = 1'b0;
        run32 = 1'b0;
    endtask

    task automatic waitReady(input bit use8, input int startEdges, output int edges);
        edges = startEdges;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (use8 ? ready8 : ready32) return;
        end
        edges = -1;
    endtask

    task automatic runAndCheck(input string name, input bit use8, input bit sgn,
                               input logic [31:0] mplier, input logic [31:0] mcand,
                               input logic [63:0] expected);
        int edges;
        applyStimulus(use8, sgn, mplier, mcand);
        waitReady(use8, 1, edges);
        checkOutput({name, " product"}, use8 ? {48'd0, prod8} : prod32, expected);
        checkOutput({name, " latency"}, 64'(edges), 64'(expLatency(use8, sgn, mplier)));
    endtask

    initial begin
        int edges;
        logic [31:0] ra, rb;
        bit rs;

        vecs[0]  = '{"u32 max*max",     1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{"u32 6*7",         1'b0, 1'b0, 32'd6,         32'd7,         64'h0000_0000_0000_002A};
        vecs[2]  = '{"s32 1*-1",        1'b0, 1'b1, 32'd1,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{"u32 1*deadbeef",  1'b0, 1'b0, 32'd1,         32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[4]  = '{"s32 min*min",     1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[5]  = '{"s32 0*-5",        1'b0, 1'b1, 32'd0,         32'hFFFF_FFFB, 64'h0};
        vecs[6]  = '{"u32 0*deadbeef",  1'b0, 1'b0, 32'd0,         32'hDEAD_BEEF, 64'h0};
        vecs[7]  = '{"s8 -128*-128",    1'b1, 1'b1, 32'h80,        32'h80,        64'h4000};
        vecs[8]  = '{"s8 -3*5",         1'b1, 1'b1, 32'hFD,        32'h05,        64'hFFF1};
        vecs[9]  = '{"s8 7*-1",         1'b1, 1'b1, 32'h07,        32'hFF,        64'hFFF9};
        vecs[10] = '{"u8 0x80*0x80",    1'b1, 1'b0, 32'h80,        32'h80,        64'h4000};
        vecs[11] = '{"u8 0xff*0xff",    1'b1, 1'b0, 32'hFF,        32'hFF,        64'hFE01};
        vecs[12] = '{"s8 127*-128",     1'b1, 1'b1, 32'h7F,        32'h80,        64'hC080};

        // Reset with Run held high must leave everything idle and zeroed.
        Reset_n = 1'b0;
        run32 = 1'b1; sgn32 = 1'b0; mplier32 = 32'h55; mcand32 = 32'hAA;
        run8  = 1'b1; sgn8  = 1'b0; mplier8  = 8'h55;  mcand8  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset prod32", prod32, 64'h0);
        checkOutput("reset busy32", 64'(busy32), 64'h0);
        checkOutput("reset ready32", 64'(ready32), 64'h0);
        checkOutput("reset prod8", {48'd0, prod8}, 64'h0);
        checkOutput("reset busy8", 64'(busy8), 64'h0);
        @(negedge clk);
        run32 = 1'b0; run8 = 1'b0;
        Reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset idle busy32", 64'(busy32), 64'h0);
        checkOutput("post-reset idle ready32", 64'(ready32), 64'h0);

        for (int i = 0; i < 13; i++) begin
            runAndCheck(vecs[i].name, vecs[i].use8, vecs[i].sgn, vecs[i].mplier,
                        vecs[i].mcand, vecs[i].expected);
        end

        // Run and operand changes while busy must not disturb the operation in flight.
        applyStimulus(1'b0, 1'b0, 32'h8000_0001, 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        run32 = 1'b1; sgn32 = 1'b1; mplier32 = 32'hFFFF_FFFF; mcand32 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        run32 = 1'b0;
        waitReady(1'b0, 7, edges);
        checkOutput("busy-ignore product", prod32, 64'h0000_0001_8000_0003);
        checkOutput("busy-ignore latency", 64'(edges), 64'(expLatency(1'b0, 1'b0, 32'h8000_0001)));
        checkOutput("done busy32", 64'(busy32), 64'h0);

        // Back-to-back: a Run in DONE is accepted and Ready drops right after.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        checkOutput("b2b ready drop", 64'(ready32), 64'h0);
        checkOutput("b2b busy rise", 64'(busy32), 64'h1);
        waitReady(1'b0, 1, edges);
        checkOutput("b2b product", prod32, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("b2b latency", 64'(edges), 64'(expLatency(1'b0, 1'b1, 32'hFFFF_FFFD)));

        // Reset in the middle of CALC clears outputs without waiting for a clock.
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("mid-reset prod32", prod32, 64'h0);
        checkOutput("mid-reset busy32", 64'(busy32), 64'h0);
        checkOutput("mid-reset ready32", 64'(ready32), 64'h0);
        @(negedge clk);
        Reset_n = 1'b1;
        runAndCheck("after reset 6*7", 1'b0, 1'b0, 32'd6, 32'd7, 64'h2A);

        for (int n = 0; n < 300; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
            if (n % 16 == 0) ra = ra >> $urandom_range(31, 0);
            runAndCheck("rand8", 1'b1, rs, ra, rb, refProduct(1'b1, rs, ra, rb));
        end
        for (int n = 0; n < 150; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1, 0));
            if (n % 4 == 0) ra = ra >> $urandom_range(31, 0);
            runAndCheck("rand32", 1'b0, rs, ra, rb, refProduct(1'b0, rs, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-add multiplier, the next generation of the fixed 32-bit unsigned CompMultiplier.
- Generalised to WIDTH bits, with a per-operation signed/unsigned mode and a Run/Busy/Ready handshake.
- Computes one multiplier bit per clock into a 2*WIDTH-bit product register.
- Sits beside the ALU in the datapath; the CPU-side controller issues Run and polls Ready.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Run  input  1  start request; sampled only when Busy=0.
- Signed_in  input  1  1 = two's-complement operands, 0 = unsigned; latched with the operands.
- Multiplier_in  input  WIDTH  multiplier operand.
- Multiplicand_in  input  WIDTH  multiplicand operand.
- Product_out  output  2*WIDTH  result; valid while Ready=1.
- Busy  output  1  operation in progress.
- Ready  output  1  result valid; held until the next accepted Run.

Behaviour:
- Reset (async assert, sync release): state IDLE, Product_out=0, Busy=0, Ready=0, counter=0, internal regs=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with Run=1 (accept cycle):
  - Latch |Multiplicand| into mcand_r.
  - Load product_r = {WIDTH'0, |Multiplier|}.
  - neg_r = Signed_in & (msb(Multiplier_in) ^ msb(Multiplicand_in)).
  - cnt = WIDTH; Ready->0; Busy->1; go to CALC.
  - Absolute value is applied only when Signed_in=1; unsigned operands load as-is.
- CALC, each cycle:
  - sum = product_r[2W-1:W] + mcand_r if product_r[0]=1, else sum = product_r[2W-1:W]; sum is W+1 bits including the carry.
  - product_r <= {sum, product_r[W-1:1]}, a logical right shift with the carry entering at the MSB.
  - cnt <= cnt-1; when cnt==1, go to FIX.
- FIX (1 cycle): product_r <= neg_r ? (~product_r + 1) : product_r; go to DONE.
- DONE: Busy=0, Ready=1; Product_out = product_r, held stable indefinitely.
- Product_out is driven from product_r at all times. It is only guaranteed meaningful when Ready=1.
- Latency: the accept edge plus WIDTH CALC cycles plus 1 FIX cycle. Ready rises WIDTH+2 clock edges after the edge that samples Run.
- Run while Busy=1: ignored. Operands are not re-sampled and there is no queueing.
- Run in DONE: accepted on that edge; Ready falls the next cycle. Back-to-back operations are allowed with no idle cycle.
- Operand changes while Busy=1: no effect, because all operands were latched at accept.
- Signed corner case: -2^(W-1) has magnitude 2^(W-1), which fits in W unsigned bits. The product magnitude is at most 2^(2W-2), so there is no overflow. The 2*WIDTH result is exact for all inputs.
- Zero operand: the normal path applies; the result is 0 and neg_r has no effect (negating 0 gives 0).
- Reset_n low mid-operation: immediate return to reset values. No partial result is retained.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, when the unprocessed multiplier bits are all zero (product_r[cnt-1:0]==0), do one final alignment shift: product_r >>= cnt, zero-filled upper.
  - Set cnt to 0 and go to FIX on that cycle.
  - Latency becomes data-dependent: minimum 3 edges (multiplier=0), maximum WIDTH+2. Results are identical to the non-EE build.
- Undefined: fixed WIDTH+2 latency. There is no barrel shifter and no zero-detect logic.

Decomposition:
- Package mul_pkg:
  - state enum mul_state_t {IDLE, CALC, FIX, DONE}.
  - Localparam helper for CNT_W.
  - Function abs_w for the conditional two's-complement absolute value.
- One sub-module, mul_ctrl: FSM, counter, Busy/Ready generation, and the early-exit decision.
- The datapath (mcand_r, product_r, adder, negate) stays in seq_multiplier.

Test Plan:
- Reset: hold Reset_n=0 then release -> Product_out=0, Busy=0, Ready=0; Run asserted during reset is not accepted.
- WIDTH=32, unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> Product_out=0xFFFFFFFE00000001; Ready rises exactly 34 edges after accept (non-EE build).
- WIDTH=8, signed: -128 * -128 -> 0x4000; -3 * 5 -> 0xFFF1; 7 * -1 -> 0xFFF9; unsigned 0x80*0x80 -> 0x4000.
- Run pulsed and operands changed while Busy -> ignored; the first result is unchanged. Then Run in DONE (back-to-back) -> Ready drops next cycle and the second result is correct.
- Reset_n asserted mid-CALC (cycle 5 of 32) -> outputs zero immediately. A subsequent 6*7 -> 42 (0x2A) with full latency.
- MUL_EARLY_EXIT_EN, WIDTH=32: multiplier 0 -> Ready at edge 3; multiplier 1, multiplicand 0xDEADBEEF -> 0x00000000DEADBEEF in fewer than 34 edges. A random signed/unsigned sweep of 10k vectors must match the reference model.
